// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: clock-sequencing controller for the pipelined MIPS CPU.
//
// Derives a registered CPU clock from the board clock. The CPU advances only when
// commanded: a debounced push-button single step, an N-cycle STEP or free RUN from
// the touchscreen, HALT, or a stop on a PC breakpoint. Each CPU clock period is two
// board clocks (one high, one low).
//
// Optional feature macro: CPU_STEP_CTRL_BP_EN
//   defined   : breakpoint registers and PC compare are present.
//   undefined : SET_BP is ignored, bp_hit is tied low, cpu_pc is unused.
//
// Ports:
//   clk        in   board clock (10 MHz)
//   resetn     in   asynchronous active-low reset
//   btn_step   in   raw, bouncing push button
//   cmd_valid  in   one-cycle command strobe
//   cmd_op     in   0 STEP, 1 RUN, 2 HALT, 3 SET_BP
//   cmd_arg    in   STEP count or breakpoint address
//   cpu_pc     in   IF-stage PC from the CPU
//   cpu_clk    out  registered CPU clock
//   busy       out  high while not IDLE
//   bp_hit     out  sticky: last run stopped on the breakpoint
//   cycle_cnt  out  number of cpu_clk rising edges since reset
//   state      out  0 IDLE, 1 PULSE_HI, 2 PULSE_LO
module cpu_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_step,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic [31:0] cpu_pc,
    output logic        cpu_clk,
    output logic        busy,
    output logic        bp_hit,
    output logic [31:0] cycle_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPulseHi = 2'd1,
        StPulseLo = 2'd2
    } state_e;

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // ---------------------------------------------------------------------------------
    // Button path: 2-flop synchronizer, debounce, rising-edge strobe
    // ---------------------------------------------------------------------------------
    logic [1:0]      sync_q;
    logic [CntW-1:0] db_cnt_q;
    logic            btn_stable_q;
    logic            btn_edge_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q       <= 2'b00;
            db_cnt_q     <= '0;
            btn_stable_q <= 1'b0;
            btn_edge_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_step};
            btn_edge_q <= 1'b0;
            if (sync_q[1] == btn_stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == CntLast) begin
                // DEBOUNCE_CYCLES consecutive samples disagreed with the stable level.
                btn_stable_q <= sync_q[1];
                btn_edge_q   <= sync_q[1];
                db_cnt_q     <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------------------
    // Command decode
    // ---------------------------------------------------------------------------------
    state_e      state_q;
    logic [31:0] remain_q;
    logic        run_mode_q;
    logic        halt_req_q;

    logic        in_idle;
    logic        cmd_step;
    logic        cmd_run;
    logic        cmd_halt;
    logic        start_step;
    logic        start_run;
    logic [31:0] step_count;
    logic        bp_match;
    logic        stop;

    assign in_idle  = (state_q == StIdle);
    assign cmd_step = cmd_valid && (cmd_op == 2'd0);
    assign cmd_run  = cmd_valid && (cmd_op == 2'd1);
    assign cmd_halt = cmd_valid && (cmd_op == 2'd2);

    // Any command in the same cycle as a button edge drops the edge.
    assign start_step = in_idle && (cmd_step || (btn_edge_q && !cmd_valid));
    assign start_run  = in_idle && cmd_run;
    assign step_count = (cmd_step && (cmd_arg != 32'd0)) ? cmd_arg : 32'd1;

`ifdef CPU_STEP_CTRL_BP_EN
    logic [31:0] bp_addr_q;
    logic        bp_en_q;
    logic        cmd_setbp;

    assign cmd_setbp = cmd_valid && (cmd_op == 2'd3);
    // Compared in PULSE_LO, i.e. against the PC the just-finished pulse produced.
    assign bp_match  = bp_en_q && (cpu_pc == bp_addr_q);
`else
    logic unused_pc;

    assign unused_pc = ^cpu_pc;
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    assign stop  = halt_req_q || bp_match || (!run_mode_q && (remain_q == 32'd1));
    assign state = state_q;

    // ---------------------------------------------------------------------------------
    // Sequencer with registered outputs
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cpu_clk    <= 1'b0;
            busy       <= 1'b0;
            cycle_cnt  <= 32'd0;
            remain_q   <= 32'd0;
            run_mode_q <= 1'b0;
            halt_req_q <= 1'b0;
`ifdef CPU_STEP_CTRL_BP_EN
            bp_hit     <= 1'b0;
            bp_addr_q  <= 32'd0;
            bp_en_q    <= 1'b0;
`endif
        end else begin
`ifdef CPU_STEP_CTRL_BP_EN
            if (cmd_setbp) begin
                bp_addr_q <= cmd_arg;
                bp_en_q   <= (cmd_arg != 32'hFFFF_FFFF);
            end
`endif
            if (cmd_halt && !in_idle) begin
                halt_req_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_step || start_run) begin
                        state_q    <= StPulseHi;
                        cpu_clk    <= 1'b1;
                        busy       <= 1'b1;
                        cycle_cnt  <= cycle_cnt + 32'd1;
                        run_mode_q <= start_run;
                        if (start_step) begin
                            remain_q <= step_count;
                        end
`ifdef CPU_STEP_CTRL_BP_EN
                        bp_hit     <= 1'b0;
`endif
                    end
                end
                StPulseHi: begin
                    // A pulse in progress always completes its low half.
                    state_q <= StPulseLo;
                    cpu_clk <= 1'b0;
                end
                StPulseLo: begin
                    if (stop) begin
                        state_q    <= StIdle;
                        busy       <= 1'b0;
                        halt_req_q <= 1'b0;
`ifdef CPU_STEP_CTRL_BP_EN
                        if (bp_match) begin
                            bp_hit <= 1'b1;
                        end
`endif
                    end else begin
                        state_q   <= StPulseHi;
                        cpu_clk   <= 1'b1;
                        cycle_cnt <= cycle_cnt + 32'd1;
                        if (!run_mode_q) begin
                            remain_q <= remain_q - 32'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    cpu_clk    <= 1'b0;
                    busy       <= 1'b0;
                    halt_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl (DEBOUNCE_CYCLES = 4). Expected values come from a
// behavioural model: a STEP of n yields max(n,1) pulses and 2*max(n,1) busy cycles, a
// breakpoint run from cycle count c to address 4*(c+k) yields k pulses, a HALT issued
// during the m-th high phase of a RUN yields m pulses, and cycle_cnt is the running
// sum of all pulses since the last reset.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        btn_step = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic [31:0] cpu_pc;
    logic        cpu_clk;
    logic        busy;
    logic        bp_hit;
    logic [31:0] cycle_cnt;
    logic [1:0]  state;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .btn_step (btn_step),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_arg  (cmd_arg),
        .cpu_pc   (cpu_pc),
        .cpu_clk  (cpu_clk),
        .busy     (busy),
        .bp_hit   (bp_hit),
        .cycle_cnt(cycle_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    // CPU model: each instruction is 4 bytes, one instruction per cpu_clk edge.
    assign cpu_pc = {cycle_cnt[29:0], 2'b00};

    int n_asserts = 0;
    int n_fail = 0;
    int pulses = 0;
    int busy_cycles = 0;
    int hi_run = 0;
    int max_hi = 0;
    int unsigned exp_cnt = 0;

    always @(posedge cpu_clk) pulses <= pulses + 1;

    always @(negedge clk) begin
        if (busy) busy_cycles <= busy_cycles + 1;
        if (cpu_clk) begin
            hi_run <= hi_run + 1;
            if (hi_run + 1 > max_hi) max_hi <= hi_run + 1;
        end else begin
            hi_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 32'd0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_step(input int unsigned n);
        int unsigned exp_p;
        int p0;
        int b0;
        bit to;
        exp_p = (n == 0) ? 1 : n;
        p0 = pulses;
        b0 = busy_cycles;
        send_cmd(2'd0, n);
        wait_idle(200, to);
        check("step_timeout", 32'(to), 32'd0);
        check("step_pulses", 32'(pulses - p0), exp_p);
        check("step_busy_cycles", 32'(busy_cycles - b0), 2 * exp_p);
        exp_cnt += exp_p;
        check("step_cycle_cnt", cycle_cnt, exp_cnt);
        check("step_state_idle", 32'(state), 32'd0);
    endtask

    // RUN, then HALT during the high phase of pulse m.
    task automatic run_and_halt(input int m);
        int p0;
        bit found;
        p0 = pulses;
        found = 1'b0;
        send_cmd(2'd1, 32'd0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_clk && (pulses - p0 == m)) begin
                found = 1'b1;
                break;
            end
        end
        check("halt_reached_pulse", 32'(found), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        @(negedge clk);
        check("halt_pulse_lo_state", 32'(state), 32'd2);
        check("halt_pulse_lo_clk", 32'(cpu_clk), 32'd0);
        @(negedge clk);
        check("halt_idle_state", 32'(state), 32'd0);
        check("halt_idle_busy", 32'(busy), 32'd0);
        check("halt_pulses", 32'(pulses - p0), 32'(m));
        exp_cnt += m;
        check("halt_cycle_cnt", cycle_cnt, exp_cnt);
        check("halt_bp_hit", 32'(bp_hit), 32'd0);
    endtask

`ifdef CPU_STEP_CTRL_BP_EN
    task automatic bp_run(input int unsigned k);
        int p0;
        bit to;
        p0 = pulses;
        send_cmd(2'd3, 4 * (exp_cnt + k));
        send_cmd(2'd1, 32'd0);
        wait_idle(200, to);
        check("bp_timeout", 32'(to), 32'd0);
        check("bp_pulses", 32'(pulses - p0), k);
        exp_cnt += k;
        check("bp_cycle_cnt", cycle_cnt, exp_cnt);
        check("bp_hit_set", 32'(bp_hit), 32'd1);
    endtask
`endif

    initial begin
        int p0;
        int b0;
        bit to;

        // Reset
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_cpu_clk", 32'(cpu_clk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed and random STEP counts (0 behaves as 1)
        run_step(3);
        run_step(0);
        for (int i = 0; i < 3; i++) run_step($urandom_range(0, 6));

        // Bouncing button, then a clean press: exactly one pulse
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            btn_step = ~btn_step;
            repeat (2) @(posedge clk);
        end
        btn_step = 1'b1;
        repeat (10) @(posedge clk);
        btn_step = 1'b0;
        repeat (12) @(posedge clk);
        wait_idle(50, to);
        check("btn_timeout", 32'(to), 32'd0);
        check("btn_pulses", 32'(pulses - p0), 32'd1);
        exp_cnt += 1;
        check("btn_cycle_cnt", cycle_cnt, exp_cnt);

        // STEP 2 in the same cycle as the debounced button edge: command wins
        p0 = pulses;
        @(posedge clk);
        #1;
        btn_step = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_arg   = 32'd2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_arg   = 32'd0;
        wait_idle(50, to);
        btn_step = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("collide_pulses", 32'(pulses - p0), 32'd2);
        exp_cnt += 2;
        check("collide_cycle_cnt", cycle_cnt, exp_cnt);

        // STEP while busy is ignored
        p0 = pulses;
        b0 = busy_cycles;
        send_cmd(2'd0, 32'd5);
        repeat (3) @(negedge clk);
        send_cmd(2'd0, 32'd2);
        wait_idle(100, to);
        check("busy_step_timeout", 32'(to), 32'd0);
        check("busy_step_pulses", 32'(pulses - p0), 32'd5);
        check("busy_step_busy_cycles", 32'(busy_cycles - b0), 32'd10);
        exp_cnt += 5;
        check("busy_step_cycle_cnt", cycle_cnt, exp_cnt);

`ifdef CPU_STEP_CTRL_BP_EN
        bp_run($urandom_range(1, 6));
        bp_run($urandom_range(1, 6));
        send_cmd(2'd3, 32'hFFFF_FFFF);
        run_and_halt($urandom_range(1, 4));
        bp_run($urandom_range(1, 6));
        // Reset from IDLE clears the sticky flag and the breakpoint
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_idle_bp_hit", 32'(bp_hit), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_cnt = 0;
        run_and_halt(3);
`else
        // Breakpoint logic absent: run passes the address and stops only on HALT
        send_cmd(2'd3, 4 * (exp_cnt + 2));
        run_and_halt($urandom_range(4, 7));
`endif

        // Reset asserted mid-pulse clears outputs without a clock edge
        send_cmd(2'd0, 32'd4);
        @(negedge clk);
        check("pre_rst_cpu_clk", 32'(cpu_clk), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_cpu_clk", 32'(cpu_clk), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_cycle_cnt", cycle_cnt, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bp_hit", 32'(bp_hit), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_cnt = 0;
        run_step(2);

        check("max_high_width", 32'(max_hi), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Clock-sequencing controller for the pipelined MIPS CPU on the FPGA board. It derives the CPU clock `cpu_clk` from the 10 MHz board clock. The CPU advances only under controller command: a single step from the debounced push button, an N-cycle step or free run from touchscreen commands, halt, or stop on a PC breakpoint. It replaces the direct button-to-`cpu_clk` register in the board top level and exports status for the LCD display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable `clk` cycles needed to accept a button level (10 ms at 10 MHz); must be ≥1.

Ports:
- `clk` in 1: board clock, 10 MHz.
- `resetn` in 1: reset, asynchronous, active-low.
- `btn_step` in 1: raw push button; asynchronous and bouncing.
- `cmd_valid` in 1: one-cycle command strobe from the touchscreen input logic.
- `cmd_op` in 2: command opcode. 0 STEP, 1 RUN, 2 HALT, 3 SET_BP.
- `cmd_arg` in 32: STEP count, or breakpoint address.
- `cpu_pc` in 32: IF-stage PC fed back from the CPU.
- `cpu_clk` out 1: registered CPU clock.
- `busy` out 1: high while the state is not IDLE.
- `bp_hit` out 1: sticky flag; the last run stopped on the breakpoint.
- `cycle_cnt` out 32: count of `cpu_clk` rising edges since reset.
- `state` out 2: 0 IDLE, 1 PULSE_HI, 2 PULSE_LO.

## Operation
- **Button path**
  - `btn_step` passes through a 2-flop synchronizer, then a debounce counter.
  - The stable level updates only after `DEBOUNCE_CYCLES` consecutive equal samples.
  - A stable 0→1 transition produces a one-cycle `btn_edge`.
- **Command handling**
  - `btn_edge` in IDLE is treated as STEP with count 1. In any other state it is dropped.
  - STEP with count 0 is treated as count 1.
  - STEP and RUN are accepted only in IDLE. Otherwise they are ignored with no side effect.
  - Accepting STEP or RUN clears `bp_hit`.
  - HALT is accepted in any state. It sets `halt_req`, which is cleared on entry to IDLE. In IDLE it has no effect.
  - SET_BP is accepted in any state: `bp_addr` ← `cmd_arg`, and `bp_en` ← (`cmd_arg` ≠ 32'hFFFFFFFF).
  - If `cmd_valid` and `btn_edge` occur in the same cycle, the command wins and the edge is dropped.
- **State machine**
  - IDLE → PULSE_HI on an accepted STEP or RUN. This loads `remain` ← count (STEP) and sets `run_mode` (RUN).
  - PULSE_HI → PULSE_LO unconditionally.
  - PULSE_LO → IDLE if any of the following holds:
    - `halt_req` is set;
    - `bp_en` is set and `cpu_pc` == `bp_addr` (in that case `bp_hit` ← 1);
    - not `run_mode` and `remain` == 1.
  - PULSE_LO → PULSE_HI otherwise; in step mode `remain` decrements.
  - `cpu_clk` = 1 exactly in PULSE_HI, driven from a register with no combinational glitching.
  - `cycle_cnt` increments on each IDLE/PULSE_LO → PULSE_HI transition and wraps from 2^32−1 to 0.
- **Breakpoint semantics**
  - The compare happens in PULSE_LO, after the pulse, using the PC that the pulse produced.
  - Starting from a PC equal to `bp_addr` therefore always executes at least one cycle.
- **Mid-run HALT**
  - A pulse in progress is never truncated: a HALT during PULSE_HI still completes PULSE_LO.

## Timing
- All outputs and state reset to 0 immediately when `resetn` is low: `cpu_clk`, `busy`, `bp_hit`, `cycle_cnt`, `state`, `remain`, `bp_addr`, `bp_en`, `halt_req`, `run_mode`, and the synchronizer and debounce registers.
- Reset asserted mid-pulse forces `cpu_clk` low asynchronously.
- CPU clock period is 2 `clk` cycles with 50% duty: high 1, low 1.
- Command accepted at edge T → `cpu_clk` high during cycle T+1.
- STEP n: exactly n pulses; `busy` high for 2n cycles.
- Button: first raw high sample → `btn_edge` after 2 + `DEBOUNCE_CYCLES` cycles → `cpu_clk` high one cycle later.
- `bp_hit` sets in the same edge as the PULSE_LO → IDLE transition.

## Configuration
- `CPU_STEP_CTRL_BP_EN` defined: breakpoint logic is present as described.
- `CPU_STEP_CTRL_BP_EN` undefined:
  - no `bp_addr`/`bp_en` registers;
  - SET_BP is ignored;
  - `bp_hit` is tied to 0;
  - `cpu_pc` is unused;
  - RUN stops only on HALT.

## Test plan
Simulation uses `DEBOUNCE_CYCLES`=4.
- Reset, then STEP `cmd_arg`=3 → 3 `cpu_clk` pulses, each 1 high / 1 low; `busy` high 6 cycles; `cycle_cnt`=3; `state` returns to 0.
- Bouncing `btn_step` (toggles every 2 cycles), then held high 10 cycles → exactly one pulse; `cycle_cnt`=1. STEP `cmd_arg`=0 → also exactly one pulse.
- SET_BP 0x00000010, then RUN with the model PC = 4×`cycle_cnt` → stops after the 4th pulse; `bp_hit`=1; `cycle_cnt`=4. Then SET_BP 0xFFFFFFFF, RUN, HALT → stops with `bp_hit`=0.
- RUN, HALT asserted during PULSE_HI → current pulse completes (`cpu_clk` high 1 cycle), IDLE follows PULSE_LO. A STEP issued while busy is ignored and `remain` is unchanged.
- `cmd_valid` STEP 2 and `btn_edge` in the same cycle → 2 pulses total. Deassert `resetn` during PULSE_HI → `cpu_clk`, `state`, `cycle_cnt` and `bp_hit` are 0 without waiting for `clk`.
- With `CPU_STEP_CTRL_BP_EN` undefined: SET_BP 0x10, then RUN → runs until HALT; `bp_hit` stays 0.
